// File: rtl/score_link_rx.sv
// score_link_rx: rebuilds remote player score words from a 6-byte serial frame.
// Latency: slot update and frame_ok/frame_err appear one cycle after the CHK byte strobe.
// Backpressure: none; every rx_done byte is consumed, stalled frames are dropped by timeout.
module score_link_rx #(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int STALE_CYCLES   = 65_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic [1:0]  board_ID,
  output logic [31:0] ext_data_1,
  output logic [31:0] ext_data_2,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID,
    S_P2,
    S_P1,
    S_P0,
    S_CHK
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q;
  logic [7:0]    id_q;
  logic [23:0]   pts_q;
  logic [7:0]    xor_q;
  logic [1:0]    bid_q;

  logic          bid_chg;
  logic          tmo;
  logic          chk_byte;
  logic          pts_ok;
  logic          frame_valid;
  logic          store;
  logic          reject;
  logic [1:0]    lower_id;
  logic          store1;
  logic          store2;
  logic [31:0]   slot_word;

  assign bid_chg  = (board_ID != bid_q);
  // Expiry on the cycle the idle count would reach the limit; a byte in that cycle wins.
  assign tmo      = (state_q != S_IDLE) && !rx_done && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign chk_byte = rx_done && (state_q == S_CHK);

  // Validation of the collected frame, evaluated while the CHK byte is on the bus
  always_comb begin
    pts_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (pts_q[4*i +: 4] > 4'd9) pts_ok = 1'b0;
    end
    frame_valid = (rx_data == xor_q) && (id_q[7:2] == 6'd0) &&
                  (id_q[1:0] != 2'd0) && (id_q[1:0] != board_ID) && pts_ok;
  end

  // A board_ID change discards the frame in flight without counting an error
  assign store     = chk_byte && frame_valid && !bid_chg;
  assign reject    = ((chk_byte && !frame_valid) || tmo) && !bid_chg;
  assign lower_id  = (board_ID == 2'd1) ? 2'd2 : 2'd1;
  assign store1    = store && (id_q[1:0] == lower_id);
  assign store2    = store && (id_q[1:0] != lower_id);
  assign slot_word = {6'b0, id_q[1:0], pts_q};

  // FSM state register and inter-byte idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bid_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      bid_q   <= board_ID;
      if (rx_done || state_q == S_IDLE) tcnt_q <= '0;
      else                              tcnt_q <= tcnt_q + TW'(1);
    end
  end

  // Next-state logic: advance one state per received byte
  always_comb begin
    state_d = state_q;
    if (bid_chg || tmo) begin
      state_d = S_IDLE;
    end else if (rx_done) begin
      case (state_q)
        S_IDLE:  if (rx_data == 8'hA5) state_d = S_ID;
        S_ID:    state_d = S_P2;
        S_P2:    state_d = S_P1;
        S_P1:    state_d = S_P0;
        S_P0:    state_d = S_CHK;
        S_CHK:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Capture ID and points bytes and keep the running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q  <= 8'd0;
      pts_q <= 24'd0;
      xor_q <= 8'd0;
    end else if (rx_done) begin
      case (state_q)
        S_ID: begin
          id_q  <= rx_data;
          xor_q <= rx_data;
        end
        S_P2: begin
          pts_q[23:16] <= rx_data;
          xor_q        <= xor_q ^ rx_data;
        end
        S_P1: begin
          pts_q[15:8] <= rx_data;
          xor_q       <= xor_q ^ rx_data;
        end
        S_P0: begin
          pts_q[7:0] <= rx_data;
          xor_q      <= xor_q ^ rx_data;
        end
        default: ;
      endcase
    end
  end

  // Result pulses and saturating reject counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      frame_ok  <= store;
      frame_err <= reject;
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef SCORE_LINK_STALE_EN
  localparam int SW = $clog2(STALE_CYCLES + 1);
  logic [SW-1:0] stale1_q, stale2_q;

  // Score slots; a slot with no fresh frame for STALE_CYCLES clocks is blanked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_data_1 <= 32'h0;
      ext_data_2 <= 32'h0;
      stale1_q   <= '0;
      stale2_q   <= '0;
    end else if (bid_chg) begin
      ext_data_1 <= 32'h0;
      ext_data_2 <= 32'h0;
      stale1_q   <= '0;
      stale2_q   <= '0;
    end else begin
      if (store1) begin
        ext_data_1 <= slot_word;
        stale1_q   <= '0;
      end else if (stale1_q == SW'(STALE_CYCLES)) begin
        ext_data_1 <= 32'h0;
      end else begin
        stale1_q <= stale1_q + SW'(1);
      end
      if (store2) begin
        ext_data_2 <= slot_word;
        stale2_q   <= '0;
      end else if (stale2_q == SW'(STALE_CYCLES)) begin
        ext_data_2 <= 32'h0;
      end else begin
        stale2_q <= stale2_q + SW'(1);
      end
    end
  end
`else
  // Score slots hold the last good frame until reset or a board_ID change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_data_1 <= 32'h0;
      ext_data_2 <= 32'h0;
    end else if (bid_chg) begin
      ext_data_1 <= 32'h0;
      ext_data_2 <= 32'h0;
    end else begin
      if (store1) ext_data_1 <= slot_word;
      if (store2) ext_data_2 <= slot_word;
    end
  end
`endif

endmodule

// File: tb/tb_score_link_rx.sv
// tb_score_link_rx: self-checking bench for score_link_rx.
// Latency: outputs sampled on the falling edge after the sampling rising edge.
// Backpressure: none; the bench drives one byte per cycle or idles.
module tb_score_link_rx;

  localparam int T  = 20;
  localparam int ST = 50;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [1:0]  board_ID;
  logic [31:0] ext_data_1;
  logic [31:0] ext_data_2;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_cnt;

  int n_chk;
  int n_fail;

  score_link_rx #(.TIMEOUT_CYCLES(T), .STALE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .board_ID(board_ID), .ext_data_1(ext_data_1), .ext_data_2(ext_data_2),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ok, input logic err,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [7:0] ec);
    check({tag, "_ok"},  32'(frame_ok),  32'(ok));
    check({tag, "_err"}, 32'(frame_err), 32'(err));
    check({tag, "_d1"},  ext_data_1, d1);
    check({tag, "_d2"},  ext_data_2, d2);
    check({tag, "_ec"},  32'(err_cnt), 32'(ec));
  endtask

  function automatic logic [47:0] mk(input logic [7:0] idb, input logic [23:0] p);
    return {8'hA5, idb, p, idb ^ p[23:16] ^ p[15:8] ^ p[7:0]};
  endfunction

  // Spec-level validity of a complete frame seen by a board with ID bid
  function automatic bit frame_good(input int bid, input logic [47:0] f);
    logic [7:0]  idb;
    logic [23:0] p;
    bit          g;
    idb = f[39:32];
    p   = f[31:8];
    g   = ((idb ^ p[23:16] ^ p[15:8] ^ p[7:0]) == f[7:0]);
    if (idb > 8'd3 || idb == 8'd0 || int'(idb) == bid) g = 0;
    for (int i = 0; i < 6; i++) if (p[4*i +: 4] > 4'd9) g = 0;
    return g;
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_cyc(input int n);
    rx_done = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [47:0] f, input bit rnd);
    int g;
    for (int i = 0; i < 6; i++) begin
      drive_byte(f[47-8*i -: 8]);
      if (i < 5 && rnd) begin
        g = int'($urandom_range(0, 2));
        if (g > 0) idle_cyc(g);
      end
    end
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    rx_done = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cyc(2);
  endtask

  typedef struct {
    logic [1:0]  bid;
    logic [47:0] f;
    int          gap;
    logic        ok;
    logic        err;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [7:0]  ec;
  } vec_t;

  vec_t v[15];

  // Random-test reference state: last good points per remote ID
  logic [23:0] pts_m[4];
  bit          has_m[4];
  int          ec_m;
  int          bid_m;

  function automatic logic [31:0] slot_val(input int id);
    return has_m[id] ? {6'b0, 2'(id), pts_m[id]} : 32'h0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      has_m[i] = 0;
      pts_m[i] = 24'h0;
    end
  endtask

  task automatic random_test(input int nframes);
    logic [47:0] f;
    logic [7:0]  idb;
    logic [23:0] p;
    int          lo, hi, k;
    bit          g;
    clear_model();
    ec_m  = 0;
    bid_m = int'(board_ID);
    for (int n = 0; n < nframes; n++) begin
      if (n % 23 == 22) begin
        k = int'($urandom_range(1, 2));
        bid_m = ((bid_m - 1 + k) % 3) + 1;
        board_ID = 2'(bid_m);
        idle_cyc(2);
        clear_model();
      end
      lo = 0;
      hi = 0;
      for (int i = 3; i >= 1; i--) if (i != bid_m) lo = i;
      for (int i = 1; i <= 3; i++) if (i != bid_m) hi = i;
      if (n % 17 == 16) begin
        k = int'($urandom_range(0, 4));
        drive_byte(8'hA5);
        for (int i = 0; i < k; i++) drive_byte(8'($urandom));
        idle_cyc(T + 2);
        if (ec_m < 255) ec_m++;
        check("rnd_abort_ec", 32'(err_cnt), 32'(ec_m));
        check("rnd_abort_d1", ext_data_1, slot_val(lo));
        check("rnd_abort_d2", ext_data_2, slot_val(hi));
      end
      idb = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {6'b0, 2'($urandom)};
      for (int i = 0; i < 6; i++)
        p[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      f = mk(idb, p);
      if ($urandom_range(0, 7) == 0) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
      g = frame_good(bid_m, f);
      send_frame(f, 1'b1);
      if (g) begin
        has_m[idb[1:0]] = 1;
        pts_m[idb[1:0]] = p;
      end else if (ec_m < 255) begin
        ec_m++;
      end
      check_out("rnd", g, !g, slot_val(lo), slot_val(hi), 8'(ec_m));
      k = int'($urandom_range(0, 3));
      if (k > 0) idle_cyc(k);
    end
  endtask

  initial begin
    logic [47:0] f;
    int          seen;
    n_chk    = 0;
    n_fail   = 0;
    rx_data  = 8'h00;
    rx_done  = 1'b0;
    board_ID = 2'd1;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    rst_n = 1'b1;
    idle_cyc(2);

`ifdef SCORE_LINK_STALE_EN
    send_frame(mk(8'h02, 24'h123456), 1'b0);
    check("stale_store", ext_data_1, 32'h0212_3456);
    for (int k = 1; k <= 51; k++) begin
      idle_cyc(1);
      if (k == 50) check("stale_c50", ext_data_1, 32'h0212_3456);
      if (k == 51) check("stale_c51", ext_data_1, 32'h0);
    end
    send_frame(mk(8'h02, 24'h000011), 1'b0);
    idle_cyc(34);
    send_frame(mk(8'h02, 24'h000022), 1'b0);
    idle_cyc(11);
    check("stale_refresh_c51", ext_data_1, 32'h0200_0022);
    idle_cyc(39);
    check("stale_refresh_c90", ext_data_1, 32'h0200_0022);
    idle_cyc(1);
    check("stale_refresh_c91", ext_data_1, 32'h0);
    check("stale_no_err", 32'(err_cnt), 32'h0);
`else
    v[0]  = '{2'd1, mk(8'h02, 24'h123456),          0, 1'b1, 1'b0, 32'h0212_3456, 32'h0,         8'd0};
    v[1]  = '{2'd1, mk(8'h03, 24'h999999) ^ 48'h1,  2, 1'b0, 1'b1, 32'h0212_3456, 32'h0,         8'd1};
    v[2]  = '{2'd1, mk(8'h03, 24'h999999),          0, 1'b1, 1'b0, 32'h0212_3456, 32'h0399_9999, 8'd1};
    v[3]  = '{2'd1, mk(8'h02, 24'h000000),          1, 1'b1, 1'b0, 32'h0200_0000, 32'h0399_9999, 8'd1};
    v[4]  = '{2'd1, mk(8'h06, 24'h000000),          0, 1'b0, 1'b1, 32'h0200_0000, 32'h0399_9999, 8'd2};
    v[5]  = '{2'd1, mk(8'h00, 24'h112233),          0, 1'b0, 1'b1, 32'h0200_0000, 32'h0399_9999, 8'd3};
    v[6]  = '{2'd1, mk(8'h01, 24'h000001),          3, 1'b0, 1'b1, 32'h0200_0000, 32'h0399_9999, 8'd4};
    v[7]  = '{2'd1, mk(8'h03, 24'h00000A),          0, 1'b0, 1'b1, 32'h0200_0000, 32'h0399_9999, 8'd5};
    v[8]  = '{2'd2, mk(8'h02, 24'h000000),          0, 1'b0, 1'b1, 32'h0,         32'h0,         8'd6};
    v[9]  = '{2'd2, mk(8'h01, 24'h1A0000),          0, 1'b0, 1'b1, 32'h0,         32'h0,         8'd7};
    v[10] = '{2'd2, mk(8'h01, 24'h123456),          1, 1'b1, 1'b0, 32'h0112_3456, 32'h0,         8'd7};
    v[11] = '{2'd2, mk(8'h03, 24'h000001),          0, 1'b1, 1'b0, 32'h0112_3456, 32'h0300_0001, 8'd7};
    v[12] = '{2'd3, mk(8'h02, 24'h250000),          2, 1'b1, 1'b0, 32'h0,         32'h0225_0000, 8'd7};
    v[13] = '{2'd3, mk(8'h01, 24'h000000),          0, 1'b1, 1'b0, 32'h0100_0000, 32'h0225_0000, 8'd7};
    v[14] = '{2'd3, mk(8'h03, 24'h000000),          2, 1'b0, 1'b1, 32'h0100_0000, 32'h0225_0000, 8'd8};
    for (int i = 0; i < 15; i++) begin
      if (v[i].bid != board_ID) begin
        board_ID = v[i].bid;
        idle_cyc(2);
      end
      send_frame(v[i].f, 1'b0);
      check_out($sformatf("vec%0d", i), v[i].ok, v[i].err, v[i].d1, v[i].d2, v[i].ec);
      if (v[i].gap > 0) begin
        idle_cyc(v[i].gap);
        check($sformatf("vec%0d_pulse_end", i), 32'(frame_ok | frame_err), 32'h0);
      end
    end

    // Bytes other than the header are ignored while idle
    drive_byte(8'h00);
    drive_byte(8'h5A);
    drive_byte(8'hFF);
    send_frame(mk(8'h02, 24'h000777), 1'b0);
    check_out("garbage", 1'b1, 1'b0, 32'h0100_0000, 32'h0200_0777, 8'd8);

    // board_ID change coinciding with the CHK byte drops the frame silently
    f = mk(8'h01, 24'h999999);
    for (int i = 0; i < 5; i++) drive_byte(f[47-8*i -: 8]);
    board_ID = 2'd2;
    drive_byte(f[7:0]);
    rx_done = 1'b0;
    check_out("bid_at_chk", 1'b0, 1'b0, 32'h0, 32'h0, 8'd8);
    idle_cyc(2);

    // Inter-byte timeout: error lands exactly T cycles after the last byte
    drive_byte(8'hA5);
    drive_byte(8'h01);
    rx_done = 1'b0;
    seen = -1;
    for (int k = 1; k <= T + 5; k++) begin
      @(negedge clk);
      if (frame_err && seen < 0) seen = k;
    end
    check("tmo_cycle", 32'(seen), 32'(T));
    check("tmo_ec", 32'(err_cnt), 32'd9);
    send_frame(mk(8'h01, 24'h000042), 1'b0);
    check_out("after_tmo", 1'b1, 1'b0, 32'h0100_0042, 32'h0, 8'd9);
    idle_cyc(1);

    // A byte on the expiry cycle is accepted
    drive_byte(8'hA5);
    drive_byte(8'h03);
    idle_cyc(T - 1);
    drive_byte(8'h00);
    check("byte_wins_noerr", 32'(frame_err), 32'h0);
    drive_byte(8'h00);
    drive_byte(8'h05);
    drive_byte(8'h06);
    rx_done = 1'b0;
    check_out("byte_wins", 1'b1, 1'b0, 32'h0100_0042, 32'h0300_0005, 8'd9);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_frame(mk(8'h01, 24'h000000) ^ 48'h1, 1'b0);
    check_out("sat", 1'b0, 1'b1, 32'h0100_0042, 32'h0300_0005, 8'hFF);

    // Slots persist with no traffic
    idle_cyc(200);
    check("hold_d1", ext_data_1, 32'h0100_0042);
    check("hold_d2", ext_data_2, 32'h0300_0005);

    // board_ID change clears both slots
    board_ID = 2'd1;
    idle_cyc(2);
    check("bidchg_d1", ext_data_1, 32'h0);
    check("bidchg_d2", ext_data_2, 32'h0);

    // Asynchronous reset mid-frame
    send_frame(mk(8'h02, 24'h000003), 1'b0);
    check("pre_rst_d1", ext_data_1, 32'h0200_0003);
    drive_byte(8'hA5);
    drive_byte(8'h02);
    drive_byte(8'h00);
    rx_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc(2);
    drive_byte(8'h00);
    drive_byte(8'h03);
    drive_byte(8'h01);
    rx_done = 1'b0;
    check_out("rst_tail", 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    send_frame(mk(8'h03, 24'h000100), 1'b0);
    check_out("post_rst", 1'b1, 1'b0, 32'h0, 32'h0300_0100, 8'h0);

    do_reset();
    random_test(200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
